mult_seq_n: RTL and testbench

Parametrised sequential shift-and-add multiplier, the W-bit successor of the fixed 4×4 unit in the 5_ALU datapath. It multiplies two W-bit operands, either unsigned or two's-complement signed depending on a per-operation mode bit, and produces a 2W-bit product. It uses an init/busy/done handshake. Latency depends on the data because the unit exits as soon as no multiplier bits remain. The ALU result mux instantiates it next to the other arithmetic units.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_sign_cond.sv | 16 +
 rtl/mult_seq_n.sv | 83 ++++++++
 tb/tb_mult_seq_n.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier: FSM state encoding
// and its width.
package mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mult_sign_cond.sv
// Operand conditioner: turns a W-bit operand into its unsigned magnitude plus a
// sign bit; in unsigned mode the operand passes through with sign 0.
module mult_sign_cond #(
  parameter int W = 8
) (
  input  logic [W-1:0] op,
  input  logic         sgn,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = sgn & op[W-1];
  // Negating -2^(W-1) yields 2^(W-1), which is the correct unsigned magnitude.
  assign mag = neg ? ('0 - op) : op;

endmodule

// File: rtl/mult_seq_n.sv
// W-bit sequential shift-and-add multiplier, unsigned or signed per operation.
// Handshake: init is accepted only in IDLE; busy covers cycles 1..DONE; done pulses once with pp valid.
module mult_seq_n
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               sgn,
  input  logic [W-1:0]       MR,
  input  logic [W-1:0]       MD,
  output logic               busy,
  output logic               done,
  output logic [2*W-1:0]     pp,
  output logic [STATE_W-1:0] dbg_state
);

  state_t         state, state_nx;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           neg;

  logic [W-1:0]   mr_mag, md_mag;
  logic           mr_neg, md_neg;

  mult_sign_cond #(.W(W)) u_cond_mr (.op(MR), .sgn(sgn), .mag(mr_mag), .neg(mr_neg));
  mult_sign_cond #(.W(W)) u_cond_md (.op(MD), .sgn(sgn), .mag(md_mag), .neg(md_neg));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (init) state_nx = CHECK;
      CHECK: begin
        if (b == '0)    state_nx = FIX;
        else if (b[0])  state_nx = ADD;
        else            state_nx = SHIFT;
      end
      ADD:     state_nx = SHIFT;
      SHIFT:   state_nx = CHECK;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      neg   <= 1'b0;
      pp    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (init) begin
            a   <= {{W{1'b0}}, md_mag};
            b   <= mr_mag;
            pp  <= '0;
            // A zero operand forces a +0 result, so the sign flag is dropped.
            neg <= (mr_neg ^ md_neg) & (|MR) & (|MD);
          end
        end
        ADD:   pp <= pp + a;
        SHIFT: begin
          a <= a << 1;
          b <= b >> 1;
        end
        FIX:   if (neg) pp <= '0 - pp;
        default: ;
      endcase
    end
  end

  assign busy      = (state == CHECK) || (state == ADD) || (state == SHIFT) ||
                     (state == FIX)   || (state == DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_seq_n.sv
// Bench for mult_seq_n: directed and random operations, expected products
// queued at drive time and popped when done pulses.
module tb_mult_seq_n;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           init;
  logic           sgn;
  logic [W-1:0]   MR, MD;
  logic           busy, done;
  logic [2*W-1:0] pp;
  logic [2:0]     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  mult_seq_n #(.W(W)) dut (
    .clk(clk), .rst(rst), .init(init), .sgn(sgn), .MR(MR), .MD(MD),
    .busy(busy), .done(done), .pp(pp), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_pp(input logic s, input logic [W-1:0] md,
                                               input logic [W-1:0] mr);
    logic [2*W-1:0] x, y;
    x = s ? {{W{md[W-1]}}, md} : {{W{1'b0}}, md};
    y = s ? {{W{mr[W-1]}}, mr} : {{W{1'b0}}, mr};
    return x * y;
  endfunction

  function automatic int model_lat(input logic s, input logic [W-1:0] mr);
    logic [W-1:0] mag;
    int m, p;
    mag = (s && mr[W-1]) ? (~mr + 1'b1) : mr;
    m = 0;
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) begin
        m = i + 1;
        p++;
      end
    end
    return 2 * m + p + 3;
  endfunction

  // poke_cyc: cycle in which a stray init with new operands is pulsed (0 = none).
  // rst_cyc: cycle in which rst is raised to abort the operation (0 = none).
  task automatic run_op(input logic s, input logic [W-1:0] md, input logic [W-1:0] mr,
                        input int poke_cyc, input int rst_cyc);
    int lat;
    logic [2*W-1:0] e;
    bit got, aborted;
    lat = model_lat(s, mr);
    @(negedge clk);
    sgn = s; MD = md; MR = mr; init = 1'b1;
    exp_q.push_back(model_pp(s, md, mr));
    @(posedge clk);
    #1 init = 1'b0;
    got = 0;
    aborted = 0;
    e = '0;
    for (int k = 1; k <= 200 && !got && !aborted; k++) begin
      @(negedge clk);
      if (rst_cyc != 0 && k == rst_cyc + 1) begin
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pp", 32'(pp), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        void'(exp_q.pop_front());
        aborted = 1;
      end else begin
        if (k <= lat) check("busy_run", 32'(busy), 32'd1);
        if (done) begin
          check("latency", 32'(k), 32'(lat));
          e = exp_q.pop_front();
          check("product", 32'(pp), 32'(e));
          got = 1;
        end
        init = 1'b0;
        if (k == poke_cyc) begin
          init = 1'b1;
          MD = W'($urandom_range(0, 255));
          MR = W'($urandom_range(0, 255));
        end
        if (k == rst_cyc) rst = 1'b1;
      end
    end
    init = 1'b0;
    if (!got && !aborted) begin
      check("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (got) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("pp_hold", 32'(pp), 32'(e));
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; sgn = 1'b0; MR = '0; MD = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pp", 32'(pp), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'd13, 8'd11, 0, 0);
    run_op(1'b1, 8'hF9, 8'd6, 0, 0);
    run_op(1'b1, 8'h80, 8'h80, 0, 0);
    run_op(1'b0, 8'h80, 8'h80, 0, 0);
    run_op(1'b0, 8'h55, 8'h00, 0, 0);
    run_op(1'b1, 8'hFB, 8'h00, 0, 0);
    run_op(1'b0, 8'hFF, 8'hFF, 5, 0);
    run_op(1'b0, 8'hFF, 8'hFF, 0, 10);
    run_op(1'b1, 8'h7F, 8'h81, 0, 0);

    // rst and init together: the request must be dropped.
    @(negedge clk);
    rst = 1'b1; init = 1'b1; sgn = 1'b0; MD = 8'd3; MR = 8'd3;
    @(negedge clk);
    rst = 1'b0; init = 1'b0;
    check("rst_init_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_init_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
             W'($urandom_range(0, 255)), 0, 0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
